// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a column shift register
// turn raster-order pixels into the eight neighbours of every interior pixel.
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic [15:0]      win_x,
    output logic [15:0]      win_y,
    output logic             frame_done
);

    localparam int          AW       = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam logic [15:0] COL_LAST = 16'(IMG_W - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMG_H - 1);

    logic [15:0] col_q, col_d, row_q, row_d;
    logic [15:0] cur_col, cur_row;
    logic        accept, emit;

    // lb_mid holds line row-1, lb_top holds line row-2
    logic [PIX_W-1:0] lb_mid [IMG_W];
    logic [PIX_W-1:0] lb_top [IMG_W];
    logic [AW-1:0]    addr;
    logic [PIX_W-1:0] mid_rd, top_rd;

    // two previous columns of each window row
    logic [PIX_W-1:0] t1_q, t2_q, m1_q, m2_q, b1_q, b2_q;

    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] p0_q, p1_q, p2_q, p3_q, p5_q, p6_q, p7_q, p8_q;
    logic [PIX_W-1:0] p0_d, p1_d, p2_d, p3_d, p5_d, p6_d, p7_d, p8_d;
    logic [15:0]      wx_q, wx_d, wy_q, wy_d;
    logic             fd_q, fd_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // start-of-frame overrides the counters so the pixel lands at (0,0)
    assign cur_col = in_sof ? 16'd0 : col_q;
    assign cur_row = in_sof ? 16'd0 : row_q;
    assign emit    = accept && (cur_row >= 16'd2) && (cur_col >= 16'd2);

    assign addr   = cur_col[AW-1:0];
    assign mid_rd = lb_mid[addr];
    assign top_rd = lb_top[addr];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[addr] <= mid_rd;
            lb_mid[addr] <= in_pixel;
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        fd_d  = 1'b0;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = 16'd0;
                row_d = (cur_row == ROW_LAST) ? 16'd0 : cur_row + 16'd1;
                fd_d  = (cur_row == ROW_LAST) && !in_sof;
            end else begin
                col_d = cur_col + 16'd1;
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        p0_d = p0_q; p1_d = p1_q; p2_d = p2_q; p3_d = p3_q;
        p5_d = p5_q; p6_d = p6_q; p7_d = p7_q; p8_d = p8_q;
        wx_d = wx_q;
        wy_d = wy_q;
        if (emit) begin
            out_valid_d = 1'b1;
            p0_d = t2_q; p1_d = t1_q; p2_d = top_rd;
            p3_d = m2_q;              p5_d = mid_rd;
            p6_d = b2_q; p7_d = b1_q; p8_d = in_pixel;
            wx_d = cur_col - 16'd1;
            wy_d = cur_row - 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            t1_q        <= '0; t2_q <= '0;
            m1_q        <= '0; m2_q <= '0;
            b1_q        <= '0; b2_q <= '0;
            out_valid_q <= 1'b0;
            p0_q <= '0; p1_q <= '0; p2_q <= '0; p3_q <= '0;
            p5_q <= '0; p6_q <= '0; p7_q <= '0; p8_q <= '0;
            wx_q        <= '0;
            wy_q        <= '0;
            fd_q        <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            p0_q <= p0_d; p1_q <= p1_d; p2_q <= p2_d; p3_q <= p3_d;
            p5_q <= p5_d; p6_q <= p6_d; p7_q <= p7_d; p8_q <= p8_d;
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            fd_q        <= fd_d;
            // col>=2 gating means stale columns from the previous line never surface
            if (accept) begin
                t2_q <= t1_q; t1_q <= top_rd;
                m2_q <= m1_q; m1_q <= mid_rd;
                b2_q <= b1_q; b1_q <= in_pixel;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign p0 = p0_q;
    assign p1 = p1_q;
    assign p2 = p2_q;
    assign p3 = p3_q;
    assign p5 = p5_q;
    assign p6 = p6_q;
    assign p7 = p7_q;
    assign p8 = p8_q;
    assign win_x      = wx_q;
    assign win_y      = wy_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image: a 2-D image array models the frame and
// every accepted interior pixel queues its expected 3x3 neighbourhood.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk, rst_n;
    logic       in_valid, in_ready, in_sof, out_valid, out_ready, frame_done;
    logic [7:0] in_pixel, p0, p1, p2, p3, p5, p6, p7, p8;
    logic [15:0] win_x, win_y;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img [H][W];
    logic [95:0] expq [$];
    int          mr, mc;
    logic        exp_fd;
    int          wins, fds, hold;
    logic [95:0] dut_win;

    assign dut_win = {p0, p1, p2, p3, p5, p6, p7, p8, win_x, win_y};

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference: place pixel in the image, emit window if it completes a 3x3 block
    task automatic model_accept(input logic [7:0] px, input logic sof);
        if (sof) begin mr = 0; mc = 0; end
        img[mr][mc] = px;
        if (mr >= 2 && mc >= 2)
            expq.push_back({img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                            img[mr-1][mc-2],                  img[mr-1][mc],
                            img[mr][mc-2],   img[mr][mc-1],   px,
                            16'(mc - 1), 16'(mr - 1)});
        exp_fd = !sof && mr == H - 1 && mc == W - 1;
        mc++;
        if (mc == W) begin mc = 0; mr = (mr == H - 1) ? 0 : mr + 1; end
    endtask

    // one clock: start at negedge, evaluate handshakes, end at the following negedge
    task automatic step(input logic v, input logic [7:0] px, input logic sof,
                        input logic ordy, output logic acc);
        in_valid = v; in_pixel = px; in_sof = sof; out_ready = ordy;
        #1;
        chk("out_valid", 96'(out_valid), 96'(expq.size() != 0));
        chk("in_ready", 96'(in_ready), 96'(!out_valid || ordy));
        if (out_valid && expq.size() != 0) begin
            chk("window", dut_win, expq[0]);
            if (ordy) begin void'(expq.pop_front()); wins++; end
        end
        acc = v && in_ready;
        exp_fd = 1'b0;
        if (acc) model_accept(px, sof);
        @(posedge clk);
        @(negedge clk);
        chk("frame_done", 96'(frame_done), 96'(exp_fd));
        if (frame_done) fds++;
    endtask

    task automatic send(input logic [7:0] px, input logic sof, input logic rnd);
        logic acc, ordy, v;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            ordy = 1'b1;
            v    = 1'b1;
            if (hold > 0 && out_valid) begin ordy = 1'b0; hold--; end
            else if (rnd) begin
                ordy = ($urandom_range(0, 3) != 0);
                v    = ($urandom_range(0, 4) != 0);
            end
            step(v, px, sof, ordy, acc);
            tries++;
        end
        if (!acc) chk("accept_timeout", 96'(acc), 96'(1));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
        mr = 0; mc = 0; exp_fd = 1'b0; wins = 0; fds = 0; hold = 0;
        #12;
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        chk("rst_window", dut_win, 96'(0));
        chk("rst_frame_done", 96'(frame_done), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // frame 1: pixel = 16*row+col, first window checked against literal values
        for (int i = 0; i < W * H; i++) begin
            send(8'(16 * (i / W) + (i % W)), i == 0, 1'b0);
            if (i == 10) begin
                chk("first_valid", 96'(out_valid), 96'(1));
                chk("first_window", dut_win,
                    {8'h00, 8'h01, 8'h02, 8'h10, 8'h12, 8'h20, 8'h21, 8'h22, 16'd1, 16'd1});
            end
        end
        drain();
        chk("frame1_windows", 96'(wins), 96'(4));
        chk("frame1_done_pulses", 96'(fds), 96'(1));

        // frame 2 back-to-back with 5 cycles of backpressure on its first window
        wins = 0; fds = 0; hold = 5;
        for (int i = 0; i < W * H; i++) send(8'(8'hA0 + i), 1'b0, 1'b0);
        drain();
        chk("frame2_windows", 96'(wins), 96'(4));
        chk("frame2_hold_used", 96'(hold), 96'(0));

        // sof at pixel 6 of a frame resyncs; partial frame gives no frame_done
        wins = 0; fds = 0;
        for (int i = 0; i < 6; i++) send(8'($urandom), i == 0, 1'b0);
        for (int i = 0; i < W * H; i++) send(8'($urandom), i == 0, 1'b0);
        drain();
        chk("sof_windows", 96'(wins), 96'(4));
        chk("sof_done_pulses", 96'(fds), 96'(1));

        // random data, gaps and backpressure over several frames
        wins = 0; fds = 0;
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < W * H; i++) send(8'($urandom), 1'b0, 1'b1);
        drain();
        chk("rand_windows", 96'(wins), 96'(24));
        chk("rand_done_pulses", 96'(fds), 96'(6));

        // async reset mid-frame while a window is pending
        for (int i = 0; i < 11; i++) send(8'($urandom), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 96'(out_valid), 96'(0));
        chk("midrst_in_ready", 96'(in_ready), 96'(1));
        chk("midrst_window", dut_win, 96'(0));
        expq.delete();
        mr = 0; mc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wins = 0; fds = 0;
        for (int i = 0; i < W * H; i++) send(8'($urandom), 1'b0, 1'b1);
        drain();
        chk("postrst_windows", 96'(wins), 96'(4));
        chk("postrst_done_pulses", 96'(fds), 96'(1));
        chk("queue_empty", 96'(expq.size()), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
